sha256_job_scheduler: RTL
=========================

// Module: sha256_job_scheduler
// PURPOSE
//   Dispatches hash jobs (message_addr, output_addr, tag) to NUM_CORES simplified SHA-256 cores.
//   Each core has the start/done/message_addr/output_addr contract; done is high while the core is idle.
//   Jobs are granted round-robin to free cores. Finished jobs are queued in a completion FIFO as (tag, core).
//   Sits between the host/job source and the core array.
// PARAMETERS
//   NUM_CORES  4  number of SHA-256 cores managed (1..16)
//   TAG_W      8  width of job tag
//   CPL_DEPTH  4  completion FIFO depth, power of 2, >=2
// PORTS
//   clk            in   1              clock
//   reset_n        in   1              asynchronous, active-low reset
//   job_valid      in   1              job request valid
//   job_ready      out  1              scheduler can accept job this cycle
//   job_msg_addr   in   16             message word address
//   job_out_addr   in   16             hash output word address
//   job_tag        in   TAG_W          opaque job id
//   core_start     out  NUM_CORES      one-cycle start pulse per core
//   core_msg_addr  out  16*NUM_CORES   per-core message_addr, core i at [16i+15:16i]
//   core_out_addr  out  16*NUM_CORES   per-core output_addr, same packing
//   core_done      in   NUM_CORES      per-core done (high = idle)
//   cpl_valid      out  1              completion FIFO non-empty
//   cpl_ready      in   1              consumer pops head when cpl_valid && cpl_ready
//   cpl_tag        out  TAG_W          tag of head completion
//   cpl_core       out  4              core index that ran head job
//   busy_count     out  5              cores not in FREE
// BEHAVIOUR
// - Reset values:
//   - job_ready=0 during reset; after reset, job_ready follows the rule below.
//   - core_start, core addresses, cpl_valid, cpl_tag, cpl_core, busy_count = 0.
//   - All cores FREE, round-robin pointer = 0, FIFO empty.
// - Per-core FSM:
//   - FREE   -> LAUNCH on grant; job addresses and tag are latched into that core's slot.
//   - LAUNCH: core_start[i]=1 for exactly this one cycle -> WAIT_ACK.
//   - WAIT_ACK: wait for core_done[i]==0 -> RUN. No timeout.
//   - RUN: wait for core_done[i]==1 -> CPL.
//   - CPL: request FIFO push; on push -> FREE.
//   - Core addresses stay stable from LAUNCH until the core returns to FREE.
//   - A core whose done was already low at reset is treated as FREE anyway.
// - Dispatch:
//   - job_ready = any core in FREE (registered state only).
//   - On job_valid && job_ready, the job goes to the first FREE core at or after rr_ptr (wrapping).
//   - rr_ptr <= granted index + 1, wrapping at NUM_CORES-1 -> 0.
//   - At most one grant per cycle. A job accepted at edge N drives core_start at N+1.
//   - job_* inputs are sampled only at the accepting edge.
// - Completion:
//   - One push per cycle. With several cores in CPL, the lowest index pushes; the others hold in CPL.
//   - Push is allowed when count<CPL_DEPTH, or when count==CPL_DEPTH and a pop occurs the same cycle.
//   - Full FIFO: cores stay in CPL (not re-grantable) and no completion is lost.
//   - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo CPL_DEPTH.
//   - cpl_tag/cpl_core show the head entry; they hold while cpl_valid && !cpl_ready.
//   - Latency: core_done rises at edge N -> RUN->CPL at N+1 -> push at N+2 -> cpl_valid earliest after N+2.
// - busy_count = number of cores in LAUNCH/WAIT_ACK/RUN/CPL, registered.
// - Reset mid-operation: everything returns to reset values and in-flight jobs are dropped.
//   Cores are reset by the same reset_n.
// TESTING
// 1 Single job (tag 8'h11, msg 16'h0000, out 16'h0100):
//   -> core_start[0] pulses 1 cycle; core0 addresses = 0000/0100.
//   -> After core done, one completion with tag 11, core 0.
// 2 Five back-to-back jobs, NUM_CORES=4:
//   -> Cores 0,1,2,3 start; job_ready=0 with the 5th pending.
//   -> The 5th goes to the first core to finish; busy_count peaks at 4.
// 3 cpl_ready held 0 while 6 jobs complete:
//   -> The FIFO holds 4; the 2 remaining cores stay in CPL with busy_count=2.
//   -> Both push after pops; tags come out in push order.
// 4 Cores 1 and 3 raise done on the same cycle:
//   -> Core 1's completion is pushed first, core 3's the next cycle.
// 5 Round-robin: cores 0 and 2 finish, rr_ptr=1.
//   -> The next job goes to core 2, then the following one to core 0.
// 6 reset_n low while 3 cores are RUN and the FIFO holds 2 entries:
//   -> All outputs return to 0, the FIFO is empty, and job_ready=1 the first cycle after release.

Source files
------------

// File: rtl/sha256_job_scheduler.sv
`default_nettype none
// sha256_job_scheduler -- round-robin dispatch of hash jobs to NUM_CORES cores, (tag, core) completion FIFO.
// Rev 1.0
module sha256_job_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int TAG_W     = 8,
  parameter int CPL_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [15:0]             job_msg_addr,
  input  logic [15:0]             job_out_addr,
  input  logic [TAG_W-1:0]        job_tag,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [16*NUM_CORES-1:0] core_msg_addr,
  output logic [16*NUM_CORES-1:0] core_out_addr,
  input  logic [NUM_CORES-1:0]    core_done,
  output logic                    cpl_valid,
  input  logic                    cpl_ready,
  output logic [TAG_W-1:0]        cpl_tag,
  output logic [3:0]              cpl_core,
  output logic [4:0]              busy_count
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PTR_W = $clog2(CPL_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_L = CPL_DEPTH[PTR_W:0];
  localparam logic [IDX_W-1:0] LAST_L  = IDX_W'(NUM_CORES - 1);

  typedef enum logic [2:0] {
    S_FREE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_RUN      = 3'd3,
    S_CPL      = 3'd4
  } core_state_t;

  core_state_t          state     [NUM_CORES];
  core_state_t          state_nxt [NUM_CORES];
  logic [15:0]          slot_msg  [NUM_CORES];
  logic [15:0]          slot_out  [NUM_CORES];
  logic [TAG_W-1:0]     slot_tag  [NUM_CORES];
  logic [TAG_W-1:0]     fifo_tag  [CPL_DEPTH];
  logic [3:0]           fifo_core [CPL_DEPTH];

  logic [NUM_CORES-1:0] is_free;
  logic [NUM_CORES-1:0] is_cpl;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     push_idx;
  logic [IDX_W-1:0]     scan_idx;
  logic                 grant_any;
  logic                 cpl_any;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [PTR_W:0]       count;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  always_comb begin
    core_start = '0;
    is_free    = '0;
    is_cpl     = '0;
    busy_count = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      core_start[k] = (state[k] == S_LAUNCH);
      is_free[k]    = (state[k] == S_FREE);
      is_cpl[k]     = (state[k] == S_CPL);
      if (state[k] != S_FREE) busy_count = busy_count + 5'd1;
    end
  end

  // Held low during reset so the host never sees a grant before the array is idle.
  assign job_ready = reset_n & (|is_free);
  assign accept    = job_valid & job_ready & grant_any;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_idx = (int'(rr_ptr) + k >= NUM_CORES) ? IDX_W'(int'(rr_ptr) + k - NUM_CORES)
                                                 : IDX_W'(int'(rr_ptr) + k);
      if (!grant_any && is_free[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    cpl_any  = 1'b0;
    push_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (is_cpl[k]) begin
        cpl_any  = 1'b1;
        push_idx = IDX_W'(k);
      end
    end
  end

  assign cpl_valid = (count != '0);
  assign pop       = cpl_valid & cpl_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = cpl_any & ((count < DEPTH_L) | pop);

  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      state_nxt[k] = state[k];
      case (state[k])
        S_FREE:     if (accept && grant_idx == IDX_W'(k)) state_nxt[k] = S_LAUNCH;
        S_LAUNCH:   state_nxt[k] = S_WAIT_ACK;
        S_WAIT_ACK: if (!core_done[k]) state_nxt[k] = S_RUN;
        S_RUN:      if (core_done[k]) state_nxt[k] = S_CPL;
        S_CPL:      if (push && push_idx == IDX_W'(k)) state_nxt[k] = S_FREE;
        default:    state_nxt[k] = S_FREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        state[k]    <= S_FREE;
        slot_msg[k] <= '0;
        slot_out[k] <= '0;
        slot_tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CORES; k++) state[k] <= state_nxt[k];
      if (accept) begin
        slot_msg[grant_idx] <= job_msg_addr;
        slot_out[grant_idx] <= job_out_addr;
        slot_tag[grant_idx] <= job_tag;
        rr_ptr              <= (grant_idx == LAST_L) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < CPL_DEPTH; k++) begin
        fifo_tag[k]  <= '0;
        fifo_core[k] <= '0;
      end
    end else begin
      if (push) begin
        fifo_tag[wr_ptr]  <= slot_tag[push_idx];
        fifo_core[wr_ptr] <= 4'(push_idx);
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign cpl_tag  = fifo_tag[rd_ptr];
  assign cpl_core = fifo_core[rd_ptr];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_pack
    assign core_msg_addr[16*i +: 16] = slot_msg[i];
    assign core_out_addr[16*i +: 16] = slot_out[i];
  end

endmodule
`default_nettype wire
